ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// ex_muldiv_unit : multi-cycle MULT/MULTU/DIV/DIVU HI/LO unit for the EX stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              cancel_i,
    output logic              busy_o,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_by_zero_o
);

    localparam int c_CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_uns;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_quo;
    logic [DATA_W-1:0]    r_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [DATA_W-1:0]    r_hi;
    logic [DATA_W-1:0]    r_lo;
    logic                 r_dbz;

    logic                 w_start;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [DATA_W-1:0]    w_mag_a;
    logic [DATA_W-1:0]    w_mag_b;
    logic [2*DATA_W-1:0]  w_ext_a;
    logic [2*DATA_W-1:0]  w_ext_b;
    logic [2*DATA_W-1:0]  w_product;
    logic [DATA_W:0]      w_trial;

    assign w_start  = (r_state == S_IDLE) && start_i && !cancel_i;
    assign w_b_zero = (opb_i == '0);

    // Only the signed ops (op_i[0]==0) interpret the sign bit
    assign w_a_neg = !op_i[0] && opa_i[DATA_W-1];
    assign w_b_neg = !op_i[0] && opb_i[DATA_W-1];
    assign w_mag_a = w_a_neg ? -opa_i : opa_i;
    assign w_mag_b = w_b_neg ? -opb_i : opb_i;

    // Product is a multicycle path: operands are stable for MUL_LAT cycles
    assign w_ext_a   = {{DATA_W{!r_uns && r_a[DATA_W-1]}}, r_a};
    assign w_ext_b   = {{DATA_W{!r_uns && r_b[DATA_W-1]}}, r_b};
    assign w_product = w_ext_a * w_ext_b;

    assign w_trial = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (cancel_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (!op_i[1])     w_next_state = S_MUL;
                        else if (w_b_zero) w_next_state = S_DONE;
                        else              w_next_state = S_DIV;
                    end
                end
                S_MUL:   if (r_cnt == '0) w_next_state = S_DONE;
                S_DIV:   if (r_cnt == '0) w_next_state = S_FIX;
                S_FIX:   w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_uns   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_uns   <= op_i[0];
                        r_a     <= opa_i;
                        r_b     <= op_i[1] ? w_mag_b : opb_i;
                        r_quo   <= w_mag_a;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= op_i[1] ? c_DIV_CNT : c_MUL_CNT;
                        if (op_i[1] && w_b_zero) begin
                            r_hi  <= opa_i;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0 && !cancel_i) begin
                        r_hi  <= w_product[2*DATA_W-1:DATA_W];
                        r_lo  <= w_product[DATA_W-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                S_DIV: begin
                    // Restoring step: keep the shifted remainder when the trial borrows
                    r_cnt <= r_cnt - 1'b1;
                    r_quo <= {r_quo[DATA_W-2:0], !w_trial[DATA_W]};
                    if (!w_trial[DATA_W]) r_rem <= w_trial[DATA_W-1:0];
                    else                  r_rem <= {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
                end
                S_FIX: begin
                    if (!cancel_i) begin
                        r_lo  <= r_neg_q ? -r_quo : r_quo;
                        r_hi  <= r_neg_r ? -r_rem : r_rem;
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign stall_req_o   = w_start || (r_state == S_MUL) || (r_state == S_DIV) ||
                           (r_state == S_FIX);
    assign done_o        = (r_state == S_DONE);
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign div_by_zero_o = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// tb_ex_muldiv_unit : directed + randomized checks of ex_muldiv_unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

    localparam int DW = 32;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          cancel;
    logic          busy;
    logic          stall;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          dbz;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [DW-1:0] prev_hi = '0;
    logic [DW-1:0] prev_lo = '0;

    ex_muldiv_unit #(.DATA_W(DW), .MUL_LAT(ML)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .opa_i         (opa),
        .opb_i         (opb),
        .cancel_i      (cancel),
        .busy_o        (busy),
        .stall_req_o   (stall),
        .done_o        (done),
        .hi_o          (hi),
        .lo_o          (lo),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the ISA definitions
    task automatic model(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] eh, output logic [DW-1:0] el,
                         output logic ed, output int elat);
        longint          sp, sq, sr;
        longint unsigned up, uq, ur;
        ed = 1'b0;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[63:32]; el = sp[31:0]; elat = ML;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32]; el = up[31:0]; elat = ML;
            end
            default: begin
                if (b == '0) begin
                    eh = a; el = '1; ed = 1'b1; elat = 0;
                end else if (o == 2'b10) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    eh = sr[31:0]; el = sq[31:0]; elat = DW + 1;
                end else begin
                    uq = {32'b0, a} / {32'b0, b};
                    ur = {32'b0, a} % {32'b0, b};
                    eh = ur[31:0]; el = uq[31:0]; elat = DW + 1;
                end
            end
        endcase
    endtask

    // n = edges after the sampling edge until done_o is seen
    task automatic wait_done(output int n, output logic got);
        n = 0;
        got = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] eh, el;
        logic          ed, got;
        int            elat, n;
        model(o, a, b, eh, el, ed, elat);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        #1 chk("stall_on_request", stall, 1'b1);
        wait_done(n, got);
        chk("done_seen", got, 1'b1);
        chk("latency", n, elat);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("div_by_zero", dbz, ed);
        chk("stall_in_done", stall, 1'b0);
        start = 1'b0;
        opa = $urandom; opb = $urandom;
        @(posedge clk); #1;
        chk("done_pulse_width", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        logic [DW-1:0] a, b, eh1, el1, eh2, el2;
        logic          ed, got;
        int            elat, n, base, r;

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", dbz, 1'b0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("plan_mult_hi", hi, 32'hFFFF_FFFF);
        chk("plan_mult_lo", lo, 32'hFFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("plan_multu_hi", hi, 32'hFFFF_FFFE);
        chk("plan_multu_lo", lo, 32'h0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("plan_div_lo", lo, 32'hFFFF_FFFD);
        chk("plan_div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd7, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("plan_div_ovf_lo", lo, 32'h8000_0000);
        chk("plan_div_ovf_hi", hi, 32'h0000_0000);
        run_op(2'b11, 32'h0000_1234, 32'h0);
        chk("plan_dbz_hi", hi, 32'h0000_1234);

        // Cancel a divide at iteration 10 (start still high: cancel wins)
        @(negedge clk);
        op = 2'b10; opa = 32'd1000; opb = 32'd7; start = 1'b1;
        base = done_cnt;
        repeat (11) @(posedge clk);
        #1;
        chk("cancel_busy_before", busy, 1'b1);
        opa = 32'd5; opb = 32'd0;
        cancel = 1'b1;
        #1 chk("cancel_over_start_stall", stall, 1'b1);
        @(posedge clk); #1;
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_done", done, 1'b0);
        chk("cancel_stall_idle", stall, 1'b0);
        @(posedge clk); #1;
        chk("cancel_idle_start_ignored", busy, 1'b0);
        cancel = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cancel_no_done", done_cnt - base, 0);
        chk("cancel_hi_kept", hi, prev_hi);
        chk("cancel_lo_kept", lo, prev_lo);

        // Back-to-back: start held through DONE, next MULT begins the cycle after
        a = 32'h0001_2345; b = 32'hFFFF_0010;
        model(2'b00, a, b, eh1, el1, ed, elat);
        @(negedge clk);
        base = done_cnt;
        op = 2'b00; opa = a; opb = b; start = 1'b1;
        wait_done(n, got);
        chk("b2b_first_done", got, 1'b1);
        chk("b2b_first_hi", hi, eh1);
        chk("b2b_first_lo", lo, el1);
        a = 32'h7FFF_FFFF; b = 32'h8000_0000;
        model(2'b00, a, b, eh2, el2, ed, elat);
        opa = a; opb = b;
        wait_done(n, got);
        chk("b2b_second_done", got, 1'b1);
        chk("b2b_second_latency", n, ML + 1);
        chk("b2b_second_hi", hi, eh2);
        chk("b2b_second_lo", lo, el2);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_pulse_count", done_cnt - base, 2);
        prev_hi = eh2; prev_lo = el2;

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 7);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case (r)
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            run_op(2'($urandom_range(0, 3)), a, b);
        end

        // Reset in the middle of a divide
        @(negedge clk);
        op = 2'b11; opa = 32'hDEAD_BEEF; opb = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_dbz", dbz, 1'b0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
